// File: rtl/out_port_arbiter.sv
// rtl/out_port_arbiter.sv - per-output-port round-robin arbiter with wormhole locking and credit flow control
module out_port_arbiter #(
  parameter int NUM_PORTS    = 5,
  parameter int ADDR_W       = 3,
  parameter int CREDIT_DEPTH = 4,
  localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*ADDR_W-1:0]   route_addr_i,
  input  logic [NUM_PORTS-1:0]          valid_i,
  input  logic [NUM_PORTS-1:0]          tail_i,
  input  logic [ADDR_W-1:0]             q_address,
  input  logic                          credit_i,
  output logic [NUM_PORTS-1:0]          grant_o,
  output logic                          pop_req_o,
  output logic                          busy_o,
  output logic [CNT_W-1:0]              credits_o,
  output logic                          err_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  ptr_t              owner;
  ptr_t              rr_ptr;
  logic [CNT_W-1:0]  credit_cnt;

  logic [NUM_PORTS-1:0] req;
  logic                 win_found;
  ptr_t                 winner;
  ptr_t                 search_idx;
  ptr_t                 xfer_port;
  logic                 xfer;
  logic                 xfer_tail;
  logic                 has_credit;

  function automatic ptr_t next_ptr(input ptr_t p);
    if (int'(p) == NUM_PORTS - 1) return '0;
    return p + ptr_t'(1);
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      req[i] = valid_i[i] && (route_addr_i[i*ADDR_W +: ADDR_W] == q_address);
  end

  // Rotating search starting at rr_ptr; the first hit in search order wins.
  always_comb begin
    win_found  = 1'b0;
    winner     = '0;
    search_idx = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!win_found && req[search_idx]) begin
        win_found = 1'b1;
        winner    = search_idx;
      end
      search_idx = next_ptr(search_idx);
    end
  end

  assign has_credit = (credit_cnt != '0);

  always_comb begin
    grant_o   = '0;
    xfer_port = winner;
    if (!rst && has_credit) begin
      if (state == IDLE) begin
        if (win_found) grant_o[winner] = 1'b1;
      end else begin
        xfer_port = owner;
        if (req[owner]) grant_o[owner] = 1'b1;
      end
    end
  end

  assign xfer      = |grant_o;
  assign pop_req_o = xfer;
  assign xfer_tail = tail_i[xfer_port];
  assign busy_o    = (state == LOCKED);
  assign credits_o = credit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      credit_cnt <= CNT_W'(CREDIT_DEPTH);
      err_o      <= 1'b0;
    end else begin
      if (xfer) begin
        if (xfer_tail) begin
          state  <= IDLE;
          rr_ptr <= next_ptr(xfer_port);
        end else if (state == IDLE) begin
          state <= LOCKED;
          owner <= winner;
        end
      end

      // Simultaneous transfer and credit return cancel out.
      case ({xfer, credit_i})
        2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01: begin
          if (credit_cnt == CNT_W'(CREDIT_DEPTH)) err_o <= 1'b1;
          else credit_cnt <= credit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// tb/tb_out_port_arbiter.sv - directed and randomized self-checking bench for out_port_arbiter
module tb_out_port_arbiter;

  localparam int NP = 5;
  localparam int AW = 3;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] Q = 3'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*AW-1:0]  route_addr = '0;
  logic [NP-1:0]     valid = '0;
  logic [NP-1:0]     tail = '0;
  logic              credit = 1'b0;
  logic [NP-1:0]     grant;
  logic              pop_req;
  logic              busy;
  logic [CW-1:0]     credits;
  logic              err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: packet-level view of the arbiter.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;
  bit m_err;

  out_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .CREDIT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .route_addr_i(route_addr), .valid_i(valid), .tail_i(tail),
    .q_address(Q), .credit_i(credit), .grant_o(grant), .pop_req_o(pop_req),
    .busy_o(busy), .credits_o(credits), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_err = 0;
  endtask

  function automatic bit wants(input int p);
    return valid[p] && (route_addr[p*AW +: AW] == Q);
  endfunction

  task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] t, input logic c);
    valid = v; tail = t; credit = c;
    for (int i = 0; i < NP; i++)
      route_addr[i*AW +: AW] = v[i] ? Q : AW'(Q + 3'd1);
  endtask

  // One clock: settle, compare against model, advance model, step to edge+1.
  // want_grant >= 0 adds a directed check against a fixed grant pattern.
  task automatic cycle(input int want_grant);
    int win;
    logic [NP-1:0] exp_g;
    #3;
    if (rst) model_reset();
    win = -1;
    if (!rst && m_cred > 0) begin
      if (!m_locked) begin
        for (int k = 0; k < NP; k++)
          if (win < 0 && wants((m_ptr + k) % NP)) win = (m_ptr + k) % NP;
      end else if (wants(m_owner)) begin
        win = m_owner;
      end
    end
    exp_g = (win >= 0) ? NP'(1 << win) : '0;
    check("grant", 32'(grant), 32'(exp_g));
    check("pop_req", 32'(pop_req), 32'(|exp_g));
    check("busy", 32'(busy), 32'(m_locked));
    check("credits", 32'(credits), 32'(m_cred));
    check("err", 32'(err), 32'(m_err));
    if (want_grant >= 0) check("grant_directed", 32'(grant), 32'(want_grant));
    if (!rst) begin
      if (win >= 0) begin
        if (tail[win]) begin
          m_locked = 0;
          m_ptr = (win + 1) % NP;
        end else if (!m_locked) begin
          m_locked = 1;
          m_owner = win;
        end
      end
      if (win >= 0 && !credit) m_cred--;
      else if (win < 0 && credit) begin
        if (m_cred == DEPTH) m_err = 1;
        else m_cred++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'b11111, 5'b11111, 1'b1);
    cycle(0);
    cycle(0);
    rst = 1'b0;
    drive('0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // Reset state with requests pending: no grant, full credits.
    do_reset();
    check("reset_credits", 32'(credits), DEPTH);
    check("reset_busy", 32'(busy), 0);

    // Single-flit packet from port 0.
    drive(5'b00001, 5'b00001, 1'b0);
    cycle(5'b00001);
    drive('0, '0, 1'b0);
    check("single_credits", 32'(credits), 3);
    check("single_busy", 32'(busy), 0);
    cycle(0);

    // Rotation among ports 0, 2, 4 with credit returned each cycle.
    do_reset();
    drive(5'b10101, 5'b10101, 1'b1);
    cycle(5'b00001);
    cycle(5'b00100);
    cycle(5'b10000);
    cycle(5'b00001);
    check("rotate_credits", 32'(credits), DEPTH);

    // 3-flit packet on port 1 locks out port 3.
    do_reset();
    drive(5'b01010, 5'b01000, 1'b0);
    cycle(5'b00010);
    check("lock_busy", 32'(busy), 1);
    cycle(5'b00010);
    drive(5'b01010, 5'b01010, 1'b0);
    cycle(5'b00010);
    check("unlock_busy", 32'(busy), 0);
    cycle(5'b01000);

    // Credit exhaustion, then one credit returns exactly one grant.
    do_reset();
    drive(5'b00001, 5'b00001, 1'b0);
    for (int i = 0; i < 4; i++) cycle(5'b00001);
    cycle(0);
    check("exhaust_credits", 32'(credits), 0);
    drive(5'b00001, 5'b00001, 1'b1);
    cycle(0);
    drive(5'b00001, 5'b00001, 1'b0);
    cycle(5'b00001);
    cycle(0);

    // Credit overflow sets a sticky error.
    do_reset();
    drive('0, '0, 1'b1);
    cycle(0);
    drive('0, '0, 1'b0);
    check("overflow_credits", 32'(credits), DEPTH);
    check("overflow_err", 32'(err), 1);
    for (int i = 0; i < 3; i++) cycle(0);
    check("err_sticky", 32'(err), 1);
    do_reset();
    check("err_cleared", 32'(err), 0);

    // Reset while locked mid-packet.
    drive(5'b00100, 5'b00000, 1'b0);
    cycle(5'b00100);
    cycle(5'b00100);
    rst = 1'b1;
    cycle(0);
    rst = 1'b0;
    drive('0, '0, 1'b0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_credits", 32'(credits), DEPTH);
    drive(5'b00101, 5'b00101, 1'b0);
    cycle(5'b00001);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      valid = NP'($urandom);
      tail = NP'($urandom);
      credit = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NP; i++)
        route_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : Q;
      cycle(-1);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
